// File: rtl/stack_game_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_game_if
// Description : Bundles the user key and all display/status signals of the
//               stack game core. The master side drives drop and observes the
//               game; the slave side (the core) does the opposite.
// Ports       : drop        - user key level (master -> slave)
//               x, prev_x   - left edge of moving / top placed block
//               blk_w       - width of the moving block
//               y           - y coordinate of the moving row
//               score       - saturating score
//               chances     - remaining chances
//               game_status - 00 idle, 01 play, 10 win, 11 lose
//               sync        - one-cycle pulse per move tick
//               placed      - one-cycle pulse per successful placement
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_game_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SCORE_W = 3
);
  logic               drop;
  logic [X_W-1:0]     x;
  logic [X_W-1:0]     prev_x;
  logic [X_W-1:0]     blk_w;
  logic [Y_W-1:0]     y;
  logic [SCORE_W-1:0] score;
  logic [1:0]         chances;
  logic [1:0]         game_status;
  logic               sync;
  logic               placed;

  modport master (
    output drop,
    input  x, prev_x, blk_w, y, score, chances, game_status, sync, placed
  );

  modport slave (
    input  drop,
    output x, prev_x, blk_w, y, score, chances, game_status, sync, placed
  );
endinterface
`default_nettype wire

// File: rtl/stack_game_core.sv
`default_nettype none
// ============================================================================
// Module      : stack_game_core
// Description : Stacking game engine. A block slides back and forth across
//               the playfield; pressing drop places it on the stack, trimming
//               it to the overlap with the block below. Misses cost a chance.
//               Stacking N_ROWS rows wins, running out of chances loses.
// Ports       : clk    - single clock
//               resetn - synchronous active-low reset
//               bus    - stack_game_if slave modport (drop in, game state out);
//                        the interface widths must match X_W/Y_W/SCORE_W
// Revision    : 1.0 - initial release
// ============================================================================
module stack_game_core #(
  parameter int SCREEN_W   = 160,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int Y_BASE     = 112,
  parameter int ROW_H      = 8,
  parameter int N_ROWS     = 12,
  parameter int INIT_BLK_W = 32,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 3,
  parameter int TICK_DIV   = 833333,
  parameter int TICK_STEP  = 20000,
  parameter int TICK_MIN   = 200000
) (
  input  logic       clk,
  input  logic       resetn,
  stack_game_if.slave bus
);

  localparam int                 ROW_W     = (N_ROWS < 1) ? 1 : $clog2(N_ROWS + 1);
  localparam logic [X_W-1:0]     PREV_X0   = X_W'((SCREEN_W - INIT_BLK_W) / 2);
  localparam logic [X_W-1:0]     INIT_W    = X_W'(INIT_BLK_W);
  localparam logic [X_W:0]       SCREEN_E  = (X_W+1)'(SCREEN_W);
  localparam logic [1:0]         LIVES_C   = 2'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_PLACE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  state_t             state;
  logic [X_W-1:0]     x;
  logic [X_W-1:0]     prev_x;
  logic [X_W-1:0]     prev_w;
  logic [X_W-1:0]     blk_w;
  logic [Y_W-1:0]     y;
  logic [ROW_W-1:0]   row;
  logic [SCORE_W-1:0] score;
  logic [1:0]         chances;
  logic [1:0]         status;
  logic               dir_right;
  logic               sync;
  logic               placed;
  logic [31:0]        tick_cnt;
  logic               drop_q;
  logic               drop_edge;

  // Rising-edge detector on the key. drop_q is forced high during reset so a
  // key held through reset release must first be let go before it counts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_q    <= 1'b1;
      drop_edge <= 1'b0;
    end else begin
      drop_q    <= bus.drop;
      drop_edge <= bus.drop & ~drop_q;
    end
  end

  // Combinational helpers: tick period, overlap, score and row update.
  logic [31:0]        row_step;
  logic [31:0]        period;
  logic               tick;
  logic [X_W:0]       x_end;
  logic [X_W:0]       p_end;
  logic [X_W:0]       lo;
  logic [X_W:0]       hi;
  logic [X_W:0]       ov;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [ROW_W-1:0]   row_inc;
  logic [Y_W-1:0]     y_next;
  logic               restart;

  always_comb begin
    row_step = 32'(row) * 32'(TICK_STEP);
    // max(TICK_DIV - row*TICK_STEP, TICK_MIN) without unsigned underflow
    if (row_step + 32'(TICK_MIN) >= 32'(TICK_DIV)) begin
      period = 32'(TICK_MIN);
    end else begin
      period = 32'(TICK_DIV) - row_step;
    end
    tick = (tick_cnt >= period - 32'd1);

    x_end = {1'b0, x} + {1'b0, blk_w};
    p_end = {1'b0, prev_x} + {1'b0, prev_w};
    lo    = (x > prev_x) ? {1'b0, x} : {1'b0, prev_x};
    hi    = (x_end < p_end) ? x_end : p_end;
    ov    = (hi > lo) ? (hi - lo) : '0;

    score_sum  = {1'b0, score} + ((x == prev_x) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];

    row_inc = row + ROW_W'(1);
    y_next  = Y_W'(Y_BASE - int'(row_inc) * ROW_H);

    restart = drop_edge && ((state == S_WIN) || (state == S_LOSE));
  end

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      state     <= S_IDLE;
      x         <= '0;
      dir_right <= 1'b1;
      row       <= '0;
      y         <= Y_W'(Y_BASE);
      prev_x    <= PREV_X0;
      prev_w    <= INIT_W;
      blk_w     <= INIT_W;
      score     <= '0;
      chances   <= LIVES_C;
      status    <= 2'b00;
      sync      <= 1'b0;
      placed    <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      sync   <= 1'b0;
      placed <= 1'b0;
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (drop_edge) begin
            state  <= S_MOVE;
            status <= 2'b01;
          end
        end

        S_MOVE: begin
          if (drop_edge) begin
            // a tick landing on the same cycle as the key is dropped
            state    <= S_PLACE;
            tick_cnt <= '0;
          end else if (tick) begin
            tick_cnt <= '0;
            sync     <= 1'b1;
            if (dir_right) begin
              if (x_end == SCREEN_E) begin
                x         <= x - X_W'(1);
                dir_right <= 1'b0;
              end else begin
                x <= x + X_W'(1);
              end
            end else begin
              if (x == '0) begin
                x         <= X_W'(1);
                dir_right <= 1'b1;
              end else begin
                x <= x - X_W'(1);
              end
            end
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end

        S_PLACE: begin
          tick_cnt <= '0;
          if (ov == '0) begin
            chances <= chances - 2'd1;
            if (chances == 2'd1) begin
              // x stays where the losing drop happened
              state  <= S_LOSE;
              status <= 2'b11;
            end else begin
              state     <= S_MOVE;
              x         <= '0;
              dir_right <= 1'b1;
            end
          end else begin
            prev_x    <= lo[X_W-1:0];
            prev_w    <= ov[X_W-1:0];
            blk_w     <= ov[X_W-1:0];
            row       <= row_inc;
            y         <= y_next;
            score     <= score_next;
            placed    <= 1'b1;
            x         <= '0;
            dir_right <= 1'b1;
            if (row_inc == ROW_W'(N_ROWS)) begin
              state  <= S_WIN;
              status <= 2'b10;
            end else begin
              state <= S_MOVE;
            end
          end
        end

        S_WIN, S_LOSE: begin
          tick_cnt <= '0;
        end

        default: begin
          state    <= S_IDLE;
          status   <= 2'b00;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.x           = x;
  assign bus.prev_x      = prev_x;
  assign bus.blk_w       = blk_w;
  assign bus.y           = y;
  assign bus.score       = score;
  assign bus.chances     = chances;
  assign bus.game_status = status;
  assign bus.sync        = sync;
  assign bus.placed      = placed;

endmodule
`default_nettype wire

// File: tb/tb_stack_game_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_game_core
// Description : Self-checking bench for stack_game_core with a fast tick
//               (period 4 cycles) and a two-row win condition. Drops are
//               timed right after a tick so the block sits still while the
//               key edge travels through the edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_game_core;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  stack_game_if #(.X_W(8), .Y_W(7), .SCORE_W(3)) bus();

  stack_game_core #(
    .SCREEN_W(160), .X_W(8), .Y_W(7), .Y_BASE(112), .ROW_H(8), .N_ROWS(2),
    .INIT_BLK_W(32), .LIVES(3), .SCORE_W(3),
    .TICK_DIV(4), .TICK_STEP(0), .TICK_MIN(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    int x; int prev_x; int blk_w; int y; int score; int chances; int status; int placed;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_fail = 0;

  // reference model of the stack
  int m_prev_x, m_prev_w, m_score, m_chances, m_row;

  task automatic model_reset();
    m_prev_x = 64; m_prev_w = 32; m_score = 0; m_chances = 3; m_row = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0; bus.drop = 1'b0;
    cycles(2);
    resetn = 1'b1;
    model_reset();
    cycles(1);
  endtask

  task automatic start_game();
    bus.drop = 1'b1;
    cycles(3);
    bus.drop = 1'b0;
    cycles(1);
  endtask

  // wait until x has just stepped onto target
  task automatic wait_fresh(input int target, output bit ok);
    int last;
    last = int'(bus.x);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (int'(bus.x) == target && last != target) begin
        ok = 1'b1;
        break;
      end
      last = int'(bus.x);
    end
  endtask

  // Drop when x reaches target; leaves drop held high on return.
  task automatic drop_at(input string tag, input int target);
    bit ok; exp_t e; int lo, hi, ov;
    bus.drop = 1'b0;
    wait_fresh(target, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_reach: x=%0d never reached %0d", tag, bus.x, target);
      return;
    end
    lo = (target > m_prev_x) ? target : m_prev_x;
    hi = (target + m_prev_w < m_prev_x + m_prev_w) ? target + m_prev_w : m_prev_x + m_prev_w;
    ov = (hi > lo) ? hi - lo : 0;
    if (ov == 0) begin
      m_chances--;
      e.placed = 0;
      e.x      = (m_chances == 0) ? target : 0;
      e.status = (m_chances == 0) ? 3 : 1;
    end else begin
      m_score += (target == m_prev_x) ? 2 : 1;
      if (m_score > 7) m_score = 7;
      m_prev_x = lo; m_prev_w = ov; m_row++;
      e.placed = 1;
      e.x      = 0;
      e.status = (m_row == 2) ? 2 : 1;
    end
    e.prev_x = m_prev_x; e.blk_w = m_prev_w; e.y = 112 - 8 * m_row;
    e.score = m_score; e.chances = m_chances;
    sb.push_back(e);

    bus.drop = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_vec += 8;
    if (int'(bus.placed) !== e.placed) begin n_fail++; $display("FAIL %s_placed: got %0d want %0d", tag, bus.placed, e.placed); end
    if (int'(bus.score) !== e.score) begin n_fail++; $display("FAIL %s_score: got %0d want %0d", tag, bus.score, e.score); end
    if (int'(bus.chances) !== e.chances) begin n_fail++; $display("FAIL %s_chances: got %0d want %0d", tag, bus.chances, e.chances); end
    if (int'(bus.game_status) !== e.status) begin n_fail++; $display("FAIL %s_status: got %0d want %0d", tag, bus.game_status, e.status); end
    if (int'(bus.prev_x) !== e.prev_x) begin n_fail++; $display("FAIL %s_prev_x: got %0d want %0d", tag, bus.prev_x, e.prev_x); end
    if (int'(bus.blk_w) !== e.blk_w) begin n_fail++; $display("FAIL %s_blk_w: got %0d want %0d", tag, bus.blk_w, e.blk_w); end
    if (int'(bus.y) !== e.y) begin n_fail++; $display("FAIL %s_y: got %0d want %0d", tag, bus.y, e.y); end
    if (int'(bus.x) !== e.x) begin n_fail++; $display("FAIL %s_x: got %0d want %0d", tag, bus.x, e.x); end
  endtask

  task automatic check_reset_values(input string tag);
    n_vec += 9;
    if (bus.game_status !== 2'b00) begin n_fail++; $display("FAIL %s_status: got %0d want 0", tag, bus.game_status); end
    if (bus.x !== 8'd0) begin n_fail++; $display("FAIL %s_x: got %0d want 0", tag, bus.x); end
    if (bus.prev_x !== 8'd64) begin n_fail++; $display("FAIL %s_prev_x: got %0d want 64", tag, bus.prev_x); end
    if (bus.blk_w !== 8'd32) begin n_fail++; $display("FAIL %s_blk_w: got %0d want 32", tag, bus.blk_w); end
    if (bus.y !== 7'd112) begin n_fail++; $display("FAIL %s_y: got %0d want 112", tag, bus.y); end
    if (bus.score !== 3'd0) begin n_fail++; $display("FAIL %s_score: got %0d want 0", tag, bus.score); end
    if (bus.chances !== 2'd3) begin n_fail++; $display("FAIL %s_chances: got %0d want 3", tag, bus.chances); end
    if (bus.sync !== 1'b0) begin n_fail++; $display("FAIL %s_sync: got %0d want 0", tag, bus.sync); end
    if (bus.placed !== 1'b0) begin n_fail++; $display("FAIL %s_placed: got %0d want 0", tag, bus.placed); end
  endtask

  task automatic test_reset();
    reset_dut();
    check_reset_values("reset");
    // key held through reset release must not start the game
    @(negedge clk);
    resetn = 1'b0; bus.drop = 1'b1;
    cycles(2);
    resetn = 1'b1;
    cycles(6);
    n_vec++;
    if (bus.game_status !== 2'b00) begin n_fail++; $display("FAIL held_drop_status: got %0d want 0", bus.game_status); end
    bus.drop = 1'b0;
    cycles(1);
  endtask

  task automatic test_tick();
    int x0, pulses;
    reset_dut();
    start_game();
    n_vec++;
    if (bus.game_status !== 2'b01) begin n_fail++; $display("FAIL start_status: got %0d want 1", bus.game_status); end
    x0 = int'(bus.x); pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.sync === 1'b1) pulses++;
    end
    n_vec += 2;
    if (pulses !== 10) begin n_fail++; $display("FAIL tick_sync_count: got %0d want 10", pulses); end
    if (int'(bus.x) !== x0 + 10) begin n_fail++; $display("FAIL tick_x: got %0d want %0d", bus.x, x0 + 10); end
  endtask

  task automatic test_perfect();
    reset_dut();
    start_game();
    drop_at("perfect", 64);
    // holding the key must not place again
    cycles(30);
    n_vec += 2;
    if (bus.y !== 7'd104) begin n_fail++; $display("FAIL held_y: got %0d want 104", bus.y); end
    if (bus.game_status !== 2'b01) begin n_fail++; $display("FAIL held_status: got %0d want 1", bus.game_status); end
    bus.drop = 1'b0;
  endtask

  task automatic test_partial();
    reset_dut();
    start_game();
    drop_at("partial", 80);
    bus.drop = 1'b0;
  endtask

  task automatic test_bounce();
    bit ok; int v;
    reset_dut();
    start_game();
    wait_fresh(128, ok);
    v = 128;
    for (int i = 0; i < 50 && int'(bus.x) == v; i++) @(negedge clk);
    n_vec += 2;
    if (!ok) begin n_fail++; $display("FAIL bounce_right_reach: x=%0d", bus.x); end
    if (bus.x !== 8'd127) begin n_fail++; $display("FAIL bounce_right: got %0d want 127", bus.x); end
    wait_fresh(0, ok);
    v = 0;
    for (int i = 0; i < 50 && int'(bus.x) == v; i++) @(negedge clk);
    n_vec += 2;
    if (!ok) begin n_fail++; $display("FAIL bounce_left_reach: x=%0d", bus.x); end
    if (bus.x !== 8'd1) begin n_fail++; $display("FAIL bounce_left: got %0d want 1", bus.x); end
  endtask

  task automatic test_lose();
    int pulses;
    reset_dut();
    start_game();
    drop_at("miss1", 100);
    drop_at("miss2", 10);
    drop_at("miss3", 10);
    bus.drop = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sync === 1'b1) pulses++;
    end
    n_vec += 3;
    if (bus.x !== 8'd10) begin n_fail++; $display("FAIL lose_x_frozen: got %0d want 10", bus.x); end
    if (pulses !== 0) begin n_fail++; $display("FAIL lose_sync: got %0d pulses want 0", pulses); end
    if (bus.game_status !== 2'b11) begin n_fail++; $display("FAIL lose_status: got %0d want 3", bus.game_status); end
    bus.drop = 1'b1;
    cycles(2);
    check_reset_values("lose_restart");
    bus.drop = 1'b0;
    model_reset();
  endtask

  task automatic test_win();
    int x0, pulses;
    reset_dut();
    start_game();
    drop_at("win1", 64);
    drop_at("win2", 64);
    bus.drop = 1'b0;
    x0 = int'(bus.x); pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sync === 1'b1) pulses++;
    end
    n_vec += 3;
    if (int'(bus.x) !== x0) begin n_fail++; $display("FAIL win_x_frozen: got %0d want %0d", bus.x, x0); end
    if (pulses !== 0) begin n_fail++; $display("FAIL win_sync: got %0d pulses want 0", pulses); end
    if (bus.score !== 3'd4) begin n_fail++; $display("FAIL win_score: got %0d want 4", bus.score); end
  endtask

  task automatic test_reset_mid_move();
    reset_dut();
    start_game();
    drop_at("pre_reset", 64);
    bus.drop = 1'b0;
    cycles(10);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    resetn = 1'b1;
    model_reset();
    cycles(2);
  endtask

  initial begin
    bus.drop = 1'b0;
    model_reset();
    test_reset();
    test_tick();
    test_perfect();
    test_partial();
    test_bounce();
    test_lose();
    test_win();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_game_core.md
STACK_GAME_CORE -- requirements
Module: stack_game_core

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, playfield width in pixels.
REQ-002 SHALL have parameter X_W, default 8, width of x, prev_x and blk_w.
REQ-003 SHALL have parameter Y_W, default 7, width of y.
REQ-004 SHALL have parameter Y_BASE, default 112, y of row 0.
REQ-005 SHALL have parameter ROW_H, default 8, pixel height per row.
REQ-006 SHALL have parameter N_ROWS, default 12, rows needed to win.
REQ-007 SHALL have parameter INIT_BLK_W, default 32, base and initial block width.
REQ-008 SHALL have parameter LIVES, default 3, initial chances.
REQ-009 SHALL have parameter SCORE_W, default 3, score width.
REQ-010 SHALL have parameters TICK_DIV 833333, TICK_STEP 20000 and TICK_MIN 200000, giving the move period in clk cycles.
REQ-011 SHALL have port clk, input, 1 bit, the single clock.
REQ-012 SHALL have port resetn, input, 1 bit, synchronous active-low reset.
REQ-013 SHALL have port drop, input, 1 bit, user key level.
REQ-014 SHALL have ports x and prev_x, outputs, X_W bits each: left edge of the moving block and of the top placed block.
REQ-015 SHALL have port blk_w, output, X_W bits, width of the moving block.
REQ-016 SHALL have port y, output, Y_W bits, y of the moving row.
REQ-017 SHALL have ports score (SCORE_W bits) and chances (2 bits), outputs.
REQ-018 SHALL have port game_status, output, 2 bits: 00 idle, 01 play, 10 win, 11 lose.
REQ-019 SHALL have ports sync (1-cycle pulse per move tick) and placed (1-cycle pulse per successful placement), outputs.

Function
REQ-020 SHALL use states IDLE, MOVE, PLACE, WIN and LOSE; game_status SHALL be 01 in MOVE and PLACE.
REQ-021 SHALL treat only a registered rising edge of drop as an event; a held level SHALL NOT repeat.
REQ-022 SHALL move from IDLE to MOVE on a drop edge.
REQ-023 In MOVE, SHALL step x by 1 per tick; tick period SHALL be max(TICK_DIV - row*TICK_STEP, TICK_MIN); sync SHALL pulse on each tick.
REQ-024 SHALL bounce at the edges: moving right with x+blk_w==SCREEN_W, the next tick SHALL give x-1 with direction left; moving left with x==0, the next tick SHALL give x=1 with direction right.
REQ-025 A drop edge in MOVE SHALL enter PLACE on the next cycle; if a tick coincides with the edge, that tick's movement SHALL be suppressed.
REQ-026 PLACE SHALL last exactly 1 cycle; all results SHALL be visible 2 cycles after the edge is sampled; drop edges in PLACE SHALL be ignored.
REQ-027 Overlap SHALL be computed with X_W+1-bit arithmetic: lo = max(x, prev_x), hi = min(x+blk_w, prev_x+prev_w), ov = hi>lo ? hi-lo : 0.
REQ-028 If ov==0: chances SHALL decrement and score SHALL be unchanged; if the new chances value is 0, SHALL go to LOSE; otherwise SHALL return to MOVE with x=0, direction right and the same row.
REQ-029 If ov>0: prev_x<=lo, prev_w<=ov, blk_w<=ov, row<=row+1, placed SHALL pulse, x=0, direction right.
REQ-030 If ov>0, score SHALL add 2 when x==prev_x (perfect), otherwise 1, saturating at 2^SCORE_W-1.
REQ-031 y SHALL equal Y_BASE - row*ROW_H.
REQ-032 If the new row equals N_ROWS, SHALL go to WIN; otherwise SHALL go to MOVE.
REQ-033 In WIN or LOSE, x, score and chances SHALL freeze and sync SHALL stay 0; a drop edge SHALL reinitialise all state to reset values and go to IDLE.
REQ-034 The tick counter SHALL clear on every state change.

Reset
REQ-035 While resetn==0 at a clk edge: state IDLE, x=0, direction right, row=0, y=Y_BASE.
REQ-036 While resetn==0 at a clk edge: prev_x=(SCREEN_W-INIT_BLK_W)/2, prev_w=blk_w=INIT_BLK_W.
REQ-037 While resetn==0 at a clk edge: score=0, chances=LIVES, game_status=00, sync=0, placed=0, drop edge register cleared.
REQ-038 Reset mid-game SHALL take effect at the next clk edge regardless of state; a drop held through reset release SHALL NOT produce an edge.

Verification
REQ-039 Sim TICK_DIV=4, TICK_STEP=0, TICK_MIN=1: start, drop at x=64 -> score=2, blk_w=32, prev_x=64, y=104, placed pulses 2 cycles after the edge.
REQ-040 Drop at x=80 -> prev_x=80, blk_w=16, score=1.
REQ-041 Drop at x=100 -> chances 3->2, score=0, x=0, row unchanged.
REQ-042 Run to x=128 with blk_w=32 -> next tick x=127; at x=0 moving left -> next tick x=1.
REQ-043 Three misses -> game_status=11, x frozen; drop -> IDLE with reset values.
REQ-044 N_ROWS=2, two perfect drops -> game_status=10, score=4; resetn low mid-MOVE -> all reset values next cycle.
